// File: rtl/wavegen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wavegen_pkg
// Description : Shared types, constants and helpers for the waveform output
//               path: frame width, DAC serialiser state encoding, and the
//               two's-complement to offset-binary conversion.
// Revision    : 1.0  initial release
// ============================================================================
package wavegen_pkg;

  localparam int FRAME_BITS = 16;

  // Serialiser state encoding
  typedef logic [2:0] state_t;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SHIFT_LO = 3'd1;
  localparam logic [2:0] ST_SHIFT_HI = 3'd2;
  localparam logic [2:0] ST_CS_HI    = 3'd3;
  localparam logic [2:0] ST_LOAD     = 3'd4;

  // Offset binary is two's complement with the sign bit inverted
  function automatic logic [FRAME_BITS-1:0] to_offset_binary(input logic [FRAME_BITS-1:0] s);
    return {~s[FRAME_BITS-1], s[FRAME_BITS-2:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dac_spi_out_if.sv
`default_nettype none
// ============================================================================
// Module      : dac_spi_out_if
// Description : Sample input, status and SPI DAC pins of the output stage.
//               master = upstream/host side, slave = dac_spi_out.
// Revision    : 1.0  initial release
// ============================================================================
interface dac_spi_out_if;
  import wavegen_pkg::*;

  logic [FRAME_BITS-1:0] sample;
  logic                  sample_valid;
  logic                  clear_ovr;
  logic                  sclk;
  logic                  sdo;
  logic                  cs_n;
  logic                  ldac_n;
  logic                  busy;
  logic                  ovr;

  modport master (
    output sample, sample_valid, clear_ovr,
    input  sclk, sdo, cs_n, ldac_n, busy, ovr
  );

  modport slave (
    input  sample, sample_valid, clear_ovr,
    output sclk, sdo, cs_n, ldac_n, busy, ovr
  );

endinterface
`default_nettype wire

// File: rtl/spi_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : spi_phase_counter
// Description : Free-running 0..CLK_DIV-1 counter that times every SPI phase.
//               phase_done flags the terminal count; restart holds it at 0.
// Revision    : 1.0  initial release
// ============================================================================
module spi_phase_counter #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic phase_done
);

  localparam int            CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  // Count phase cycles, wrapping on the terminal count so each timed state
  // lasts exactly CLK_DIV cycles without an explicit restart
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (restart || (r_count == TERMINAL)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign phase_done = (r_count == TERMINAL);

endmodule
`default_nettype wire

// File: rtl/dac_spi_out.sv
`default_nettype none
// ============================================================================
// Module      : dac_spi_out
// Description : Captures a signed sample on a strobe, converts it to offset
//               binary, shifts it MSB-first to a 16-bit SPI DAC, then pulses
//               LDAC. Samples arriving mid-frame are dropped and flagged.
// Revision    : 1.0  initial release
// ============================================================================
module dac_spi_out
  import wavegen_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 16
) (
  input  logic          clk,
  input  logic          reset,
  dac_spi_out_if.slave  bus
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  logic [2:0]        r_state;
  logic [DATA_W-1:0] r_shift;
  logic [3:0]        r_bit_cnt;
  logic              r_sclk;
  logic              r_sdo;
  logic              r_cs_n;
  logic              r_ldac_n;
  logic              r_busy;
  logic              r_ovr;
  logic              w_phase_done;
  logic              w_restart;
  logic [DATA_W-1:0] w_offset;

  assign w_offset  = to_offset_binary(bus.sample);
  // Hold the phase counter at zero while idle so the first SHIFT_LO is full length
  assign w_restart = (r_state == ST_IDLE);

  spi_phase_counter #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk        (clk),
    .reset      (reset),
    .restart    (w_restart),
    .phase_done (w_phase_done)
  );

  // Frame sequencer: every output pin is a register updated on state changes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_sclk    <= 1'b0;
      r_sdo     <= 1'b0;
      r_cs_n    <= 1'b1;
      r_ldac_n  <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.sample_valid) begin
            r_shift   <= w_offset;
            r_sdo     <= w_offset[DATA_W-1];
            r_cs_n    <= 1'b0;
            r_bit_cnt <= LAST_BIT;
            r_busy    <= 1'b1;
            r_state   <= ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          if (w_phase_done) begin
            r_sclk  <= 1'b1;
            r_state <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (w_phase_done) begin
            r_sclk <= 1'b0;
            if (r_bit_cnt != 4'd0) begin
              // Next bit moves with the falling sclk edge for full setup time
              r_bit_cnt <= r_bit_cnt - 4'd1;
              r_shift   <= r_shift << 1;
              r_sdo     <= r_shift[DATA_W-2];
              r_state   <= ST_SHIFT_LO;
            end else begin
              r_cs_n  <= 1'b1;
              r_sdo   <= 1'b0;
              r_state <= ST_CS_HI;
            end
          end
        end
        ST_CS_HI: begin
          if (w_phase_done) begin
            r_ldac_n <= 1'b0;
            r_state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_phase_done) begin
            r_ldac_n <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky overrun: a strobe while busy sets it, and setting beats clearing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovr <= 1'b0;
    end else if (bus.sample_valid && (r_state != ST_IDLE)) begin
      r_ovr <= 1'b1;
    end else if (bus.clear_ovr) begin
      r_ovr <= 1'b0;
    end
  end

  assign bus.sclk   = r_sclk;
  assign bus.sdo    = r_sdo;
  assign bus.cs_n   = r_cs_n;
  assign bus.ldac_n = r_ldac_n;
  assign bus.busy   = r_busy;
  assign bus.ovr    = r_ovr;

endmodule
`default_nettype wire
